// File: rtl/amba3_axi_slave_mem_pkg.sv
// Shared AXI3 types for the slave memory: burst/response/lock encodings,
// attribute types and the write/read FSM state enums.
package pkg_amba3;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_type_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_type_t;

  typedef enum logic [1:0] {
    LOCK_NORMAL    = 2'b00,
    LOCK_EXCLUSIVE = 2'b01,
    LOCK_LOCKED    = 2'b10,
    LOCK_RSVD      = 2'b11
  } lock_type_t;

  typedef logic [3:0] cache_attr_t;
  typedef logic [2:0] prot_attr_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } amba3_axi_wstate_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } amba3_axi_rstate_t;

endpackage

// File: rtl/amba3_axi_slave_mem_if.sv
// AXI3 channel bundle (AW/W/B/AR/R) with master and slave views.
interface amba3_axi_slave_mem_if
  import pkg_amba3::*;
#(
  parameter int TXID_SIZE = 4,
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32
);
  localparam int STRB_SIZE = DATA_SIZE / 8;

  logic [TXID_SIZE-1:0] awid;
  logic [ADDR_SIZE-1:0] awaddr;
  logic [3:0]           awlen;
  logic [2:0]           awsize;
  burst_type_t          awburst;
  lock_type_t           awlock;
  cache_attr_t          awcache;
  prot_attr_t           awprot;
  logic                 awvalid;
  logic                 awready;

  logic [TXID_SIZE-1:0] wid;
  logic [DATA_SIZE-1:0] wdata;
  logic [STRB_SIZE-1:0] wstrb;
  logic                 wlast;
  logic                 wvalid;
  logic                 wready;

  logic [TXID_SIZE-1:0] bid;
  resp_type_t           bresp;
  logic                 bvalid;
  logic                 bready;

  logic [TXID_SIZE-1:0] arid;
  logic [ADDR_SIZE-1:0] araddr;
  logic [3:0]           arlen;
  logic [2:0]           arsize;
  burst_type_t          arburst;
  lock_type_t           arlock;
  cache_attr_t          arcache;
  prot_attr_t           arprot;
  logic                 arvalid;
  logic                 arready;

  logic [TXID_SIZE-1:0] rid;
  logic [DATA_SIZE-1:0] rdata;
  resp_type_t           rresp;
  logic                 rlast;
  logic                 rvalid;
  logic                 rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/amba3_axi_slave_mem_burst_addr.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
// Reserved burst encoding steps like INCR.
module amba3_axi_burst_addr
  import pkg_amba3::*;
#(
  parameter int ADDR_SIZE = 32
) (
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [3:0]           len,
  input  logic [2:0]           size,
  input  burst_type_t          burst,
  output logic [ADDR_SIZE-1:0] next_addr
);

  logic [ADDR_SIZE-1:0] step;
  logic [ADDR_SIZE-1:0] incr_addr;
  logic [ADDR_SIZE-1:0] wrap_mask;

  always_comb begin
    step      = ADDR_SIZE'(1) << size;
    incr_addr = addr + step;
    // window size is (len+1) beats; the mask keeps the step inside it
    wrap_mask = ((ADDR_SIZE'(len) + ADDR_SIZE'(1)) << size) - ADDR_SIZE'(1);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/amba3_axi_slave_mem.sv
// AXI3 slave backed by a word memory, independent write and read FSMs.
// Optional error reporting (range, wid, wlast) via AMBA3_AXI_SLAVE_ERR_EN.
//
// state  | meaning
// W_IDLE | awready high, waiting for a write command
// W_DATA | wready high, one memory write per W beat
// W_RESP | bvalid high until bready
// R_IDLE | arready high, first word fetched on the AR handshake
// R_DATA | rvalid high, next word fetched on each R handshake
module amba3_axi_slave_mem
  import pkg_amba3::*;
#(
  parameter int TXID_SIZE = 4,
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32,
  parameter int MEM_DEPTH = 1024
) (
  input logic                  aclk,
  input logic                  areset,
  amba3_axi_slave_mem_if.slave axi
);

  localparam int STRB_SIZE = DATA_SIZE / 8;
  localparam int ADDR_LSB  = $clog2(STRB_SIZE);
  localparam int MEM_AW    = $clog2(MEM_DEPTH);

  logic [DATA_SIZE-1:0] mem_q [MEM_DEPTH];

`ifdef AMBA3_AXI_SLAVE_ERR_EN
  function automatic logic out_of_range(input logic [ADDR_SIZE-1:0] a);
    return |(a >> (ADDR_LSB + MEM_AW));
  endfunction
`endif

  amba3_axi_wstate_t    wstate_q, wstate_d;
  logic [TXID_SIZE-1:0] awid_q, awid_d;
  logic [ADDR_SIZE-1:0] waddr_q, waddr_d, waddr_next;
  logic [3:0]           awlen_q, awlen_d;
  logic [2:0]           awsize_q, awsize_d;
  burst_type_t          awburst_q, awburst_d;
  logic [3:0]           wcnt_q, wcnt_d;
  logic                 werr_q, werr_d;
  logic                 w_last_beat, w_oor, w_beat_err, mem_we;
  logic [MEM_AW-1:0]    mem_widx;

  amba3_axi_rstate_t    rstate_q, rstate_d;
  logic [TXID_SIZE-1:0] arid_q, arid_d;
  logic [ADDR_SIZE-1:0] raddr_q, raddr_d, raddr_next, rd_addr;
  logic [3:0]           arlen_q, arlen_d;
  logic [2:0]           arsize_q, arsize_d;
  burst_type_t          arburst_q, arburst_d;
  logic [3:0]           rcnt_q, rcnt_d;
  logic [DATA_SIZE-1:0] rdata_q, rdata_d, rd_beat_data;
  resp_type_t           rresp_q, rresp_d, rd_beat_resp;

  amba3_axi_burst_addr #(.ADDR_SIZE(ADDR_SIZE)) u_waddr (
    .addr(waddr_q), .len(awlen_q), .size(awsize_q), .burst(awburst_q), .next_addr(waddr_next)
  );

  amba3_axi_burst_addr #(.ADDR_SIZE(ADDR_SIZE)) u_raddr (
    .addr(raddr_q), .len(arlen_q), .size(arsize_q), .burst(arburst_q), .next_addr(raddr_next)
  );

  assign w_last_beat = (wcnt_q == awlen_q);
  assign mem_widx    = waddr_q[ADDR_LSB +: MEM_AW];

`ifdef AMBA3_AXI_SLAVE_ERR_EN
  assign w_oor      = out_of_range(waddr_q);
  assign w_beat_err = w_oor | (axi.wid != awid_q) | (axi.wlast != w_last_beat);
`else
  assign w_oor      = 1'b0;
  assign w_beat_err = 1'b0;
`endif

  assign mem_we = !areset && (wstate_q == W_DATA) && axi.wvalid && !w_oor;

  // write path: next state
  always_comb begin
    wstate_d  = wstate_q;
    awid_d    = awid_q;
    waddr_d   = waddr_q;
    awlen_d   = awlen_q;
    awsize_d  = awsize_q;
    awburst_d = awburst_q;
    wcnt_d    = wcnt_q;
    werr_d    = werr_q;
    case (wstate_q)
      W_IDLE: if (axi.awvalid) begin
        awid_d    = axi.awid;
        waddr_d   = axi.awaddr;
        awlen_d   = axi.awlen;
        awsize_d  = axi.awsize;
        awburst_d = axi.awburst;
        wcnt_d    = 4'd0;
        werr_d    = 1'b0;
        wstate_d  = W_DATA;
      end
      W_DATA: if (axi.wvalid) begin
        waddr_d = waddr_next;
        wcnt_d  = wcnt_q + 4'd1;
        werr_d  = werr_q | w_beat_err;
        if (w_last_beat) wstate_d = W_RESP;
      end
      W_RESP: if (axi.bready) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  // write path: outputs
  always_comb begin
    axi.awready = (wstate_q == W_IDLE);
    axi.wready  = (wstate_q == W_DATA);
    axi.bvalid  = (wstate_q == W_RESP);
    axi.bid     = awid_q;
    axi.bresp   = werr_q ? RESP_SLVERR : RESP_OKAY;
  end

  // read path: the fetch address is the command address in idle, else the next beat
  always_comb begin
    rd_addr      = (rstate_q == R_IDLE) ? axi.araddr : raddr_next;
    rd_beat_data = mem_q[rd_addr[ADDR_LSB +: MEM_AW]];
    rd_beat_resp = RESP_OKAY;
`ifdef AMBA3_AXI_SLAVE_ERR_EN
    if (out_of_range(rd_addr)) begin
      rd_beat_data = '0;
      rd_beat_resp = RESP_SLVERR;
    end
`endif
  end

  always_comb begin
    rstate_d  = rstate_q;
    arid_d    = arid_q;
    raddr_d   = raddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    rcnt_d    = rcnt_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (rstate_q)
      R_IDLE: if (axi.arvalid) begin
        arid_d    = axi.arid;
        raddr_d   = axi.araddr;
        arlen_d   = axi.arlen;
        arsize_d  = axi.arsize;
        arburst_d = axi.arburst;
        rcnt_d    = 4'd0;
        rdata_d   = rd_beat_data;
        rresp_d   = rd_beat_resp;
        rstate_d  = R_DATA;
      end
      R_DATA: if (axi.rready) begin
        if (rcnt_q == arlen_q) begin
          rstate_d = R_IDLE;
        end else begin
          raddr_d = raddr_next;
          rcnt_d  = rcnt_q + 4'd1;
          rdata_d = rd_beat_data;
          rresp_d = rd_beat_resp;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    axi.arready = (rstate_q == R_IDLE);
    axi.rvalid  = (rstate_q == R_DATA);
    axi.rid     = arid_q;
    axi.rdata   = rdata_q;
    axi.rresp   = rresp_q;
    axi.rlast   = (rstate_q == R_DATA) && (rcnt_q == arlen_q);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wstate_q  <= W_IDLE;
      awid_q    <= '0;
      waddr_q   <= '0;
      awlen_q   <= '0;
      awsize_q  <= '0;
      awburst_q <= BURST_FIXED;
      wcnt_q    <= '0;
      werr_q    <= 1'b0;
      rstate_q  <= R_IDLE;
      arid_q    <= '0;
      raddr_q   <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= BURST_FIXED;
      rcnt_q    <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      wstate_q  <= wstate_d;
      awid_q    <= awid_d;
      waddr_q   <= waddr_d;
      awlen_q   <= awlen_d;
      awsize_q  <= awsize_d;
      awburst_q <= awburst_d;
      wcnt_q    <= wcnt_d;
      werr_q    <= werr_d;
      rstate_q  <= rstate_d;
      arid_q    <= arid_d;
      raddr_q   <= raddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      arburst_q <= arburst_d;
      rcnt_q    <= rcnt_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // memory survives reset; only strobed byte lanes are written
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_SIZE; b++) begin
        if (axi.wstrb[b]) mem_q[mem_widx][8*b +: 8] <= axi.wdata[8*b +: 8];
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{axi.awlock, axi.awcache, axi.awprot, axi.arlock, axi.arcache,
                       axi.arprot, axi.wid, axi.wlast};

endmodule

// File: tb/tb_amba3_axi_slave_mem.sv
// Directed bench for amba3_axi_slave_mem: single-beat vector table plus
// burst, backpressure, reset and error sequences.
module tb_amba3_axi_slave_mem;
  import pkg_amba3::*;

`ifdef AMBA3_AXI_SLAVE_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  amba3_axi_slave_mem_if #(.TXID_SIZE(4), .ADDR_SIZE(32), .DATA_SIZE(32)) axi ();

  amba3_axi_slave_mem #(.TXID_SIZE(4), .ADDR_SIZE(32), .DATA_SIZE(32), .MEM_DEPTH(1024)) dut (
    .aclk(aclk), .areset(areset), .axi(axi)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] wbuf [16];
  logic [31:0] ebuf [16];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } vec_t;
  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic aw_issue(input string name, input logic [3:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input logic [2:0] size, input burst_type_t burst);
    logic rdy;
    axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awsize = size;
    axi.awburst = burst; axi.awvalid = 1'b1;
    rdy = 1'b0;
    for (int n = 0; n < 20 && !rdy; n++) begin
      rdy = axi.awready;
      tick();
    end
    axi.awvalid = 1'b0;
    chk({name, " aw_accept"}, rdy, 1);
  endtask

  task automatic w_beats(input string name, input logic [3:0] len, input logic [3:0] strb,
                         input logic [3:0] wid, input int last_at);
    logic rdy;
    for (int b = 0; b <= int'(len); b++) begin
      axi.wid = wid; axi.wdata = wbuf[b]; axi.wstrb = strb;
      axi.wlast = (b == last_at); axi.wvalid = 1'b1;
      rdy = 1'b0;
      for (int n = 0; n < 20 && !rdy; n++) begin
        rdy = axi.wready;
        tick();
      end
      if (!rdy) begin
        chk($sformatf("%s w_accept[%0d]", name, b), rdy, 1);
        break;
      end
    end
    axi.wvalid = 1'b0;
    axi.wlast = 1'b0;
  endtask

  task automatic b_collect(input string name, input logic [3:0] id, input resp_type_t exp_resp);
    axi.bready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (axi.bvalid) break;
      tick();
    end
    chk({name, " bvalid"}, axi.bvalid, 1);
    if (axi.bvalid) begin
      chk({name, " bresp"}, axi.bresp, exp_resp);
      chk({name, " bid"}, axi.bid, id);
      tick();
    end
    axi.bready = 1'b0;
  endtask

  task automatic axi_write(input string name, input logic [3:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [2:0] size, input burst_type_t burst,
                           input logic [3:0] strb, input logic [3:0] wid, input int last_at,
                           input resp_type_t exp_resp);
    aw_issue(name, id, addr, len, size, burst);
    w_beats(name, len, strb, wid, last_at);
    b_collect(name, id, exp_resp);
  endtask

  task automatic ar_issue(input string name, input logic [3:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input logic [2:0] size, input burst_type_t burst);
    logic rdy;
    axi.arid = id; axi.araddr = addr; axi.arlen = len; axi.arsize = size;
    axi.arburst = burst; axi.arvalid = 1'b1;
    rdy = 1'b0;
    for (int n = 0; n < 20 && !rdy; n++) begin
      rdy = axi.arready;
      tick();
    end
    axi.arvalid = 1'b0;
    chk({name, " ar_accept"}, rdy, 1);
  endtask

  task automatic axi_read(input string name, input logic [3:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input logic [2:0] size, input burst_type_t burst,
                          input resp_type_t exp_resp);
    ar_issue(name, id, addr, len, size, burst);
    axi.rready = 1'b1;
    for (int b = 0; b <= int'(len); b++) begin
      for (int n = 0; n < 20; n++) begin
        if (axi.rvalid) break;
        tick();
      end
      chk($sformatf("%s rvalid[%0d]", name, b), axi.rvalid, 1);
      chk($sformatf("%s rdata[%0d]", name, b), axi.rdata, ebuf[b]);
      chk($sformatf("%s rresp[%0d]", name, b), axi.rresp, exp_resp);
      chk($sformatf("%s rlast[%0d]", name, b), axi.rlast, (b == int'(len)));
      chk($sformatf("%s rid[%0d]", name, b), axi.rid, id);
      tick();
    end
    axi.rready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    axi.awvalid = 0; axi.awid = 0; axi.awaddr = 0; axi.awlen = 0; axi.awsize = 0;
    axi.awburst = BURST_INCR; axi.awlock = LOCK_NORMAL; axi.awcache = 4'h0; axi.awprot = 3'h0;
    axi.wvalid = 0; axi.wid = 0; axi.wdata = 0; axi.wstrb = 0; axi.wlast = 0; axi.bready = 0;
    axi.arvalid = 0; axi.arid = 0; axi.araddr = 0; axi.arlen = 0; axi.arsize = 0;
    axi.arburst = BURST_INCR; axi.arlock = LOCK_NORMAL; axi.arcache = 4'h0; axi.arprot = 3'h0;
    axi.rready = 0;

    vecs[0]  = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'hF};
    vecs[1]  = '{1'b1, 32'h0000_0000, 32'h1234_5678, 4'b0101};
    vecs[2]  = '{1'b0, 32'h0000_0000, 32'hFF34_FF78, 4'h0};
    vecs[3]  = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF};
    vecs[4]  = '{1'b1, 32'h0000_0100, 32'h0000_AA00, 4'b0010};
    vecs[5]  = '{1'b0, 32'h0000_0100, 32'hDEAD_AAEF, 4'h0};
    vecs[6]  = '{1'b1, 32'h0000_0104, 32'h1111_1111, 4'hF};
    vecs[7]  = '{1'b1, 32'h0000_0104, 32'hCAFE_F00D, 4'b1000};
    vecs[8]  = '{1'b0, 32'h0000_0104, 32'hCA11_1111, 4'h0};
    vecs[9]  = '{1'b1, 32'h0000_0108, 32'h5555_5555, 4'hF};
    vecs[10] = '{1'b1, 32'h0000_0108, 32'h0000_0000, 4'h0};
    vecs[11] = '{1'b0, 32'h0000_0108, 32'h5555_5555, 4'h0};

    // reset state
    tick(); tick(); tick();
    chk("rst awready", axi.awready, 1);
    chk("rst arready", axi.arready, 1);
    chk("rst wready", axi.wready, 0);
    chk("rst bvalid", axi.bvalid, 0);
    chk("rst rvalid", axi.rvalid, 0);
    chk("rst rlast", axi.rlast, 0);
    chk("rst bid", axi.bid, 0);
    chk("rst rid", axi.rid, 0);
    chk("rst bresp", axi.bresp, RESP_OKAY);
    chk("rst rresp", axi.rresp, RESP_OKAY);
    chk("rst rdata", axi.rdata, 0);
    areset = 1'b0;
    tick();

    // single-beat strobe vectors
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) begin
        wbuf[0] = vecs[i].data;
        axi_write($sformatf("vec%0d", i), 4'd1, vecs[i].addr, 4'd0, 3'd2, BURST_INCR,
                  vecs[i].strb, 4'd1, 0, RESP_OKAY);
      end else begin
        ebuf[0] = vecs[i].data;
        axi_read($sformatf("vec%0d", i), 4'd1, vecs[i].addr, 4'd0, 3'd2, BURST_INCR, RESP_OKAY);
      end
    end

    // INCR burst write and readback
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 32'hA0 + i;
      ebuf[i] = 32'hA0 + i;
    end
    axi_write("incr_wr", 4'd2, 32'h10, 4'd3, 3'd2, BURST_INCR, 4'hF, 4'd2, 3, RESP_OKAY);
    axi_read("incr_rd", 4'd3, 32'h10, 4'd3, 3'd2, BURST_INCR, RESP_OKAY);

    // WRAP read 0x38 -> 0x38,0x3C,0x30,0x34
    for (int i = 0; i < 4; i++) wbuf[i] = 32'h30 + 4 * i;
    axi_write("wrap_pre", 4'd1, 32'h30, 4'd3, 3'd2, BURST_INCR, 4'hF, 4'd1, 3, RESP_OKAY);
    ebuf[0] = 32'h38; ebuf[1] = 32'h3C; ebuf[2] = 32'h30; ebuf[3] = 32'h34;
    axi_read("wrap_rd", 4'd5, 32'h38, 4'd3, 3'd2, BURST_WRAP, RESP_OKAY);

    // WRAP write 0x58: D0->0x58, D1->0x5C, D2->0x50, D3->0x54
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hD0 + i;
    axi_write("wrap_wr", 4'd6, 32'h58, 4'd3, 3'd2, BURST_WRAP, 4'hF, 4'd6, 3, RESP_OKAY);
    ebuf[0] = 32'hD2; ebuf[1] = 32'hD3; ebuf[2] = 32'hD0; ebuf[3] = 32'hD1;
    axi_read("wrap_wr_rd", 4'd6, 32'h50, 4'd3, 3'd2, BURST_INCR, RESP_OKAY);

    // FIXED: last beat wins; FIXED read repeats the word
    wbuf[0] = 32'h1; wbuf[1] = 32'h2; wbuf[2] = 32'h3;
    axi_write("fixed_wr", 4'd7, 32'h40, 4'd2, 3'd2, BURST_FIXED, 4'hF, 4'd7, 2, RESP_OKAY);
    ebuf[0] = 32'h3; ebuf[1] = 32'h3;
    axi_read("fixed_rd", 4'd7, 32'h40, 4'd1, 3'd2, BURST_FIXED, RESP_OKAY);

    // reserved burst steps as INCR
    wbuf[0] = 32'hE0; wbuf[1] = 32'hE1;
    axi_write("rsvd_wr", 4'd8, 32'h60, 4'd1, 3'd2, BURST_RSVD, 4'hF, 4'd8, 1, RESP_OKAY);
    ebuf[0] = 32'hE0; ebuf[1] = 32'hE1;
    axi_read("rsvd_rd", 4'd8, 32'h60, 4'd1, 3'd2, BURST_INCR, RESP_OKAY);

    // R backpressure: rready 1,0,0,1 then stall on the last beat
    ar_issue("bp_rd", 4'd6, 32'h10, 4'd3, 3'd2, BURST_INCR);
    axi.rready = 1'b1;
    chk("bp beat0 rdata", axi.rdata, 32'hA0);
    tick();
    axi.rready = 1'b0;
    chk("bp beat1 rdata", axi.rdata, 32'hA1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("bp stall%0d rvalid", i), axi.rvalid, 1);
      chk($sformatf("bp stall%0d rdata", i), axi.rdata, 32'hA1);
      chk($sformatf("bp stall%0d rlast", i), axi.rlast, 0);
    end
    axi.rready = 1'b1;
    tick();
    chk("bp beat2 rdata", axi.rdata, 32'hA2);
    tick();
    axi.rready = 1'b0;
    chk("bp beat3 rdata", axi.rdata, 32'hA3);
    tick();
    chk("bp last stall rdata", axi.rdata, 32'hA3);
    chk("bp last stall rlast", axi.rlast, 1);
    chk("bp last stall rvalid", axi.rvalid, 1);
    axi.rready = 1'b1;
    tick();
    chk("bp done rvalid", axi.rvalid, 0);
    axi.rready = 1'b0;

    // B backpressure: bvalid/bid held, pending AW not accepted
    wbuf[0] = 32'h7777_7777;
    aw_issue("bp_wr", 4'd9, 32'h300, 4'd0, 3'd2, BURST_INCR);
    w_beats("bp_wr", 4'd0, 4'hF, 4'd9, 0);
    for (int n = 0; n < 20; n++) begin
      if (axi.bvalid) break;
      tick();
    end
    axi.awid = 4'd2; axi.awaddr = 32'h304; axi.awlen = 4'd0; axi.awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_b%0d bvalid", i), axi.bvalid, 1);
      chk($sformatf("bp_b%0d bid", i), axi.bid, 4'd9);
      chk($sformatf("bp_b%0d awready", i), axi.awready, 0);
      tick();
    end
    axi.bready = 1'b1;
    tick();
    axi.awvalid = 1'b0;
    axi.bready = 1'b0;
    chk("bp_b done bvalid", axi.bvalid, 0);
    chk("bp_b done awready", axi.awready, 1);
    ebuf[0] = 32'h7777_7777;
    axi_read("bp_wr_rd", 4'd9, 32'h300, 4'd0, 3'd2, BURST_INCR, RESP_OKAY);

    // reset during beat 3 of an 8-beat read
    for (int i = 0; i < 8; i++) begin
      wbuf[i] = 32'h5000_0000 + i;
      ebuf[i] = 32'h5000_0000 + i;
    end
    axi_write("rst_pre", 4'd1, 32'h200, 4'd7, 3'd2, BURST_INCR, 4'hF, 4'd1, 7, RESP_OKAY);
    ar_issue("rst_rd", 4'd7, 32'h200, 4'd7, 3'd2, BURST_INCR);
    axi.rready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      chk($sformatf("rst_rd rdata[%0d]", b), axi.rdata, ebuf[b]);
      tick();
    end
    chk("rst_rd beat3 rvalid", axi.rvalid, 1);
    chk("rst_rd beat3 rdata", axi.rdata, 32'h5000_0003);
    axi.rready = 1'b0;
    areset = 1'b1;
    tick(); tick();
    areset = 1'b0;
    chk("midrst rvalid", axi.rvalid, 0);
    chk("midrst arready", axi.arready, 1);
    chk("midrst rid", axi.rid, 0);
    chk("midrst rlast", axi.rlast, 0);
    axi_read("post_rst", 4'd4, 32'h200, 4'd7, 3'd2, BURST_INCR, RESP_OKAY);

    // out-of-range write / read (word 0 holds 0xFF34FF78)
    wbuf[0] = 32'hABCD_EF01;
    axi_write("oor_wr", 4'd3, 32'h1000, 4'd0, 3'd2, BURST_INCR, 4'hF, 4'd3, 0,
              ERR ? RESP_SLVERR : RESP_OKAY);
    ebuf[0] = ERR ? 32'hFF34_FF78 : 32'hABCD_EF01;
    axi_read("oor_word0", 4'd3, 32'h0, 4'd0, 3'd2, BURST_INCR, RESP_OKAY);
    ebuf[0] = ERR ? 32'h0 : 32'hABCD_EF01;
    axi_read("oor_rd", 4'd3, 32'h1000, 4'd0, 3'd2, BURST_INCR, ERR ? RESP_SLVERR : RESP_OKAY);

    // wid mismatch: data still written
    wbuf[0] = 32'h1357_2468;
    axi_write("wid_mm", 4'd4, 32'h0, 4'd0, 3'd2, BURST_INCR, 4'hF, 4'd5, 0,
              ERR ? RESP_SLVERR : RESP_OKAY);
    ebuf[0] = 32'h1357_2468;
    axi_read("wid_mm_rd", 4'd4, 32'h0, 4'd0, 3'd2, BURST_INCR, RESP_OKAY);

    // wlast early on a 2-beat burst, then missing on a 1-beat burst
    wbuf[0] = 32'h11; wbuf[1] = 32'h22;
    axi_write("wlast_early", 4'd2, 32'h70, 4'd1, 3'd2, BURST_INCR, 4'hF, 4'd2, 0,
              ERR ? RESP_SLVERR : RESP_OKAY);
    ebuf[0] = 32'h11; ebuf[1] = 32'h22;
    axi_read("wlast_early_rd", 4'd2, 32'h70, 4'd1, 3'd2, BURST_INCR, RESP_OKAY);
    wbuf[0] = 32'h33;
    axi_write("wlast_missing", 4'd2, 32'h78, 4'd0, 3'd2, BURST_INCR, 4'hF, 4'd2, -1,
              ERR ? RESP_SLVERR : RESP_OKAY);
    ebuf[0] = 32'h33;
    axi_read("wlast_missing_rd", 4'd2, 32'h78, 4'd0, 3'd2, BURST_INCR, RESP_OKAY);

    // clean write after errors returns OKAY
    wbuf[0] = 32'h4444_4444;
    axi_write("clean_wr", 4'd1, 32'h7C, 4'd0, 3'd2, BURST_INCR, 4'hF, 4'd1, 0, RESP_OKAY);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
